core_stim_driver: RTL and testbench

- Synthesizable, parametrised stimulus/checker engine for the core op/in/out handshake protocol.
- Fetches op codes from an op ROM and issues them when the DUT signals op-ready.
- Streams a configurable-length feature-map burst for the load op, and checks every DUT output word against a golden ROM.
- Sits between three external combinational-read ROMs and the DUT; used for on-chip/emulation self-test in place of a behavioural bench.

---
 rtl/core_pkg.sv | 20 ++
 rtl/core_out_checker.sv | 63 ++++++
 rtl/core_stim_driver.sv | 145 ++++++++++++++
 tb/tb_core_stim_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core op/in/out stimulus driver: protocol widths,
// the default load op code and the sequencer state encoding.
package core_pkg;

  localparam int CORE_OP_W      = 4;
  localparam int CORE_DATA_W    = 8;
  localparam int CORE_OUT_W     = 14;
  localparam int CORE_LOAD_MODE = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ISSUE    = 3'd2,
    S_GAP      = 3'd3,
    S_LOAD     = 3'd4,
    S_DRAIN    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/core_out_checker.sv
// Compares every DUT output word against the golden ROM and keeps the
// error count, first-mismatch index and overflow flag for one run.
module core_out_checker
  import core_pkg::*;
#(
  parameter int OUT_W = CORE_OUT_W,
  parameter int GD_AW = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [GD_AW:0]   i_gold_num,
  input  logic             i_out_valid,
  input  logic [OUT_W-1:0] i_out_data,
  output logic [GD_AW-1:0] o_gd_addr,
  input  logic [OUT_W-1:0] i_gd_rdata,
  output logic [GD_AW:0]   o_gd_cnt,
  output logic [15:0]      o_err_cnt,
  output logic [GD_AW-1:0] o_first_err_idx,
  output logic             o_overflow
);

  logic [GD_AW:0] gd_cnt;
  logic           err_seen;
  logic [15:0]    err_inc;

  assign err_inc   = (o_err_cnt == 16'hFFFF) ? o_err_cnt : o_err_cnt + 16'd1;
  assign o_gd_addr = gd_cnt[GD_AW-1:0];
  assign o_gd_cnt  = gd_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gd_cnt          <= '0;
      err_seen        <= 1'b0;
      o_err_cnt       <= '0;
      o_first_err_idx <= '0;
      o_overflow      <= 1'b0;
    end else if (i_clear) begin
      gd_cnt          <= '0;
      err_seen        <= 1'b0;
      o_err_cnt       <= '0;
      o_first_err_idx <= '0;
      o_overflow      <= 1'b0;
    end else if (i_en && i_out_valid) begin
      // Words beyond the expected count are errors but never advance the address.
      if (gd_cnt == i_gold_num) begin
        o_overflow <= 1'b1;
        o_err_cnt  <= err_inc;
      end else begin
        gd_cnt <= gd_cnt + 1'b1;
        if (i_out_data != i_gd_rdata) begin
          o_err_cnt <= err_inc;
          if (!err_seen) begin
            o_first_err_idx <= gd_cnt[GD_AW-1:0];
            err_seen        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/core_stim_driver.sv
// Stimulus/checker engine: fetches ops from a ROM, issues them to the DUT,
// streams load bursts, checks DUT output and guards the run with a watchdog.
module core_stim_driver
  import core_pkg::*;
#(
  parameter int OP_W      = CORE_OP_W,
  parameter int DATA_W    = CORE_DATA_W,
  parameter int OUT_W     = CORE_OUT_W,
  parameter int OP_AW     = 10,
  parameter int IN_AW     = 11,
  parameter int GD_AW     = 12,
  parameter int LOAD_MODE = CORE_LOAD_MODE,
  parameter int TO_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [OP_AW:0]    i_op_num,
  input  logic [IN_AW:0]    i_in_num,
  input  logic [GD_AW:0]    i_gold_num,
  input  logic [TO_W-1:0]   i_timeout,
  output logic [OP_AW-1:0]  o_op_addr,
  input  logic [OP_W-1:0]   i_op_rdata,
  output logic [IN_AW-1:0]  o_in_addr,
  input  logic [DATA_W-1:0] i_in_rdata,
  output logic [GD_AW-1:0]  o_gd_addr,
  input  logic [OUT_W-1:0]  i_gd_rdata,
  output logic              o_op_valid,
  output logic [OP_W-1:0]   o_op_mode,
  input  logic              i_op_ready,
  output logic              o_in_valid,
  output logic [DATA_W-1:0] o_in_data,
  input  logic              i_in_ready,
  input  logic              i_out_valid,
  input  logic [OUT_W-1:0]  i_out_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_err_cnt,
  output logic [GD_AW-1:0]  o_first_err_idx,
  output logic              o_timeout,
  output logic              o_overflow,
  output state_t            o_dbg_state
);

  // Handshakes: an op transfers in the single ISSUE cycle (the DUT's ready was
  // already seen in WAIT_RDY); an in-word transfers on any edge where
  // o_in_valid & i_in_ready; DUT output words transfer whenever i_out_valid.
  state_t            state, state_nx;
  logic [OP_AW:0]    op_idx, op_num_q;
  logic [IN_AW:0]    in_idx, in_num_q;
  logic [GD_AW:0]    gold_num_q, gd_cnt;
  logic [TO_W-1:0]   to_q, idle_cnt;
  logic [OP_W-1:0]   op_mode_q;
  logic              timeout_q;
  logic              start_ok, busy, op_fire, in_fire, in_last, progress, timeout_hit;

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign start_ok    = i_start && !busy;
  assign op_fire     = (state == S_ISSUE);
  assign in_fire     = (state == S_LOAD) && i_in_ready;
  assign in_last     = ((in_idx + 1'b1) == in_num_q);
  assign progress    = op_fire || in_fire || i_out_valid;
  assign timeout_hit = busy && !progress && (to_q != '0) && ((idle_cnt + 1'b1) == to_q);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (i_start) state_nx = (i_op_num == '0) ? S_DRAIN : S_WAIT_RDY;
      S_WAIT_RDY:     if (i_op_ready) state_nx = S_ISSUE;
      S_ISSUE:        state_nx = ((op_mode_q == OP_W'(LOAD_MODE)) && (in_num_q != '0)) ? S_LOAD : S_GAP;
      S_GAP:          state_nx = (op_idx < op_num_q) ? S_WAIT_RDY : S_DRAIN;
      S_LOAD:         if (in_fire && in_last) state_nx = S_GAP;
      S_DRAIN:        if (gd_cnt == gold_num_q) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
    if (timeout_hit) state_nx = S_DONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      op_idx     <= '0;
      in_idx     <= '0;
      op_num_q   <= '0;
      in_num_q   <= '0;
      gold_num_q <= '0;
      to_q       <= '0;
      idle_cnt   <= '0;
      op_mode_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        op_idx     <= '0;
        in_idx     <= '0;
        op_num_q   <= i_op_num;
        in_num_q   <= i_in_num;
        gold_num_q <= i_gold_num;
        to_q       <= i_timeout;
        idle_cnt   <= '0;
        op_mode_q  <= '0;
        timeout_q  <= 1'b0;
      end else begin
        if ((state == S_WAIT_RDY) && i_op_ready) op_mode_q <= i_op_rdata;
        if (op_fire) op_idx <= op_idx + 1'b1;
        // Each burst restarts at address 0.
        if (in_fire) in_idx <= in_last ? '0 : in_idx + 1'b1;
        idle_cnt <= (busy && !progress) ? idle_cnt + 1'b1 : '0;
        if (timeout_hit) timeout_q <= 1'b1;
      end
    end
  end

  core_out_checker #(
    .OUT_W(OUT_W),
    .GD_AW(GD_AW)
  ) u_checker (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clear         (start_ok),
    .i_en            (state != S_IDLE),
    .i_gold_num      (gold_num_q),
    .i_out_valid     (i_out_valid),
    .i_out_data      (i_out_data),
    .o_gd_addr       (o_gd_addr),
    .i_gd_rdata      (i_gd_rdata),
    .o_gd_cnt        (gd_cnt),
    .o_err_cnt       (o_err_cnt),
    .o_first_err_idx (o_first_err_idx),
    .o_overflow      (o_overflow)
  );

  // Valids decode straight from state so an async reset drops them at once.
  assign o_op_valid  = (state == S_ISSUE);
  assign o_in_valid  = (state == S_LOAD);
  assign o_in_data   = o_in_valid ? i_in_rdata : '0;
  assign o_in_addr   = in_idx[IN_AW-1:0];
  assign o_op_addr   = op_idx[OP_AW-1:0];
  assign o_op_mode   = op_mode_q;
  assign o_busy      = busy;
  assign o_done      = (state == S_DONE);
  assign o_timeout   = timeout_q;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_core_stim_driver.sv
// Self-checking bench for core_stim_driver: ROM models, a randomised DUT
// model, a monitor and a specification-level reference model.
module tb_core_stim_driver;
  import core_pkg::*;

  localparam int OP_W = 4, DATA_W = 8, OUT_W = 14;
  localparam int OP_AW = 10, IN_AW = 11, GD_AW = 12, TO_W = 16;
  localparam int LOADM = 0;

  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0;
  logic [OP_AW:0] i_op_num = '0;
  logic [IN_AW:0] i_in_num = '0;
  logic [GD_AW:0] i_gold_num = '0;
  logic [TO_W-1:0] i_timeout = '0;
  logic [OP_AW-1:0] o_op_addr;
  logic [OP_W-1:0] i_op_rdata;
  logic [IN_AW-1:0] o_in_addr;
  logic [DATA_W-1:0] i_in_rdata;
  logic [GD_AW-1:0] o_gd_addr;
  logic [OUT_W-1:0] i_gd_rdata;
  logic o_op_valid, o_in_valid, o_busy, o_done, o_timeout, o_overflow;
  logic [OP_W-1:0] o_op_mode;
  logic [DATA_W-1:0] o_in_data;
  logic [15:0] o_err_cnt;
  logic [GD_AW-1:0] o_first_err_idx;
  logic i_op_ready = 1'b0, i_in_ready = 1'b0, i_out_valid = 1'b0;
  logic [OUT_W-1:0] i_out_data = '0;
  state_t o_dbg_state;

  logic [OP_W-1:0] op_rom [0:(1<<OP_AW)-1];
  logic [DATA_W-1:0] in_rom [0:(1<<IN_AW)-1];
  logic [OUT_W-1:0] gd_rom [0:(1<<GD_AW)-1];
  logic [OUT_W-1:0] out_words [0:63];

  assign i_op_rdata = op_rom[o_op_addr];
  assign i_in_rdata = in_rom[o_in_addr];
  assign i_gd_rdata = gd_rom[o_gd_addr];

  core_stim_driver #(
    .OP_W(OP_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .OP_AW(OP_AW), .IN_AW(IN_AW),
    .GD_AW(GD_AW), .LOAD_MODE(LOADM), .TO_W(TO_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op_num(i_op_num),
    .i_in_num(i_in_num), .i_gold_num(i_gold_num), .i_timeout(i_timeout),
    .o_op_addr(o_op_addr), .i_op_rdata(i_op_rdata), .o_in_addr(o_in_addr),
    .i_in_rdata(i_in_rdata), .o_gd_addr(o_gd_addr), .i_gd_rdata(i_gd_rdata),
    .o_op_valid(o_op_valid), .o_op_mode(o_op_mode), .i_op_ready(i_op_ready),
    .o_in_valid(o_in_valid), .o_in_data(o_in_data), .i_in_ready(i_in_ready),
    .i_out_valid(i_out_valid), .i_out_data(i_out_data), .o_busy(o_busy),
    .o_done(o_done), .o_err_cnt(o_err_cnt), .o_first_err_idx(o_first_err_idx),
    .o_timeout(o_timeout), .o_overflow(o_overflow), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- DUT model (driver) ----------------
  bit drv_en = 0, mon_en = 0;
  int rdy_mode = 0, in_mode = 1, n_out = 0, out_idx = 0;

  always @(posedge i_clk) begin
    #2;
    if (drv_en) begin
      case (rdy_mode)
        1: i_op_ready = 1'b1;
        2: i_op_ready = 1'($urandom_range(0, 1));
        default: i_op_ready = 1'b0;
      endcase
      case (in_mode)
        1: i_in_ready = 1'b1;
        2: i_in_ready = ~i_in_ready;
        default: i_in_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_idx < n_out && $urandom_range(0, 1) == 1) begin
        i_out_valid = 1'b1;
        i_out_data  = out_words[out_idx];
        out_idx++;
      end else begin
        i_out_valid = 1'b0;
        i_out_data  = '0;
      end
    end else begin
      i_op_ready = 1'b0; i_in_ready = 1'b0; i_out_valid = 1'b0; i_out_data = '0;
      out_idx = 0;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, last_op_cyc = 0, gap_err = 0, hold_err = 0;
  bit have_op = 0, prev_stall = 0;
  logic [IN_AW-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic [OP_W-1:0] got_ops[$];
  logic [IN_AW+DATA_W-1:0] got_in[$];

  always @(negedge i_clk) begin
    cyc++;
    if (mon_en) begin
      if (o_op_valid) begin
        if (have_op && (cyc - last_op_cyc) < 2) gap_err++;
        have_op = 1; last_op_cyc = cyc;
        got_ops.push_back(o_op_mode);
      end
      if (prev_stall && o_in_valid && (o_in_addr != prev_addr || o_in_data != prev_data)) hold_err++;
      if (o_in_valid && i_in_ready) got_in.push_back({o_in_addr, o_in_data});
      prev_stall = o_in_valid && !i_in_ready;
      prev_addr = o_in_addr; prev_data = o_in_data;
    end else begin
      have_op = 0; prev_stall = 0; gap_err = 0; hold_err = 0;
      got_ops.delete(); got_in.delete();
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0, n_fail = 0;
  bit hung_seen = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic run_case(input int op_n, input int in_n, input int gd_n, input int rm,
                          input int im, input int nout, input bit use_tab,
                          input logic [15:0] t_err, input logic [11:0] t_first,
                          input logic t_ovf, input string nm);
    logic [OP_W-1:0] exp_q[$];
    logic [IN_AW+DATA_W-1:0] exp_in_q[$];
    int m_err, m_first, nbad, bound;
    bit m_ovf, seen, ok;
    // Reference model: op stream, burst contents and checker results.
    m_err = 0; m_first = 0; m_ovf = 0; seen = 0;
    for (int i = 0; i < op_n; i++) begin
      exp_q.push_back(op_rom[i]);
      if (op_rom[i] == OP_W'(LOADM) && in_n != 0)
        for (int j = 0; j < in_n; j++) exp_in_q.push_back({IN_AW'(j), in_rom[j]});
    end
    for (int i = 0; i < nout; i++) begin
      if (i < gd_n) begin
        if (out_words[i] != gd_rom[i]) begin
          m_err++;
          if (!seen) m_first = i;
          seen = 1;
        end
      end else begin
        m_err++; m_ovf = 1;
      end
    end
    if (m_err > 65535) m_err = 65535;
    if (use_tab) begin m_err = t_err; m_first = t_first; m_ovf = t_ovf; end

    rdy_mode = rm; in_mode = im; n_out = nout;
    i_op_num = (OP_AW+1)'(op_n); i_in_num = (IN_AW+1)'(in_n);
    i_gold_num = (GD_AW+1)'(gd_n); i_timeout = '0;
    @(posedge i_clk); #3; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0; drv_en = 1; mon_en = 1;
    ok = 0;
    bound = hung_seen ? 300 : 5000;
    for (int c = 0; c < bound; c++) begin
      @(negedge i_clk);
      if (o_done && out_idx >= nout) begin ok = 1; break; end
    end
    if (!ok) hung_seen = 1;
    repeat (3) @(negedge i_clk);
    #1;
    check({nm, "_done"}, 32'(ok), 1);
    check({nm, "_ops_cnt"}, got_ops.size(), exp_q.size());
    nbad = 0;
    for (int i = 0; i < got_ops.size() && i < exp_q.size(); i++) if (got_ops[i] != exp_q[i]) nbad++;
    check({nm, "_ops_bad"}, nbad, 0);
    check({nm, "_in_cnt"}, got_in.size(), exp_in_q.size());
    nbad = 0;
    for (int i = 0; i < got_in.size() && i < exp_in_q.size(); i++) if (got_in[i] != exp_in_q[i]) nbad++;
    check({nm, "_in_bad"}, nbad, 0);
    check({nm, "_op_gap"}, gap_err, 0);
    check({nm, "_in_hold"}, hold_err, 0);
    check({nm, "_err_cnt"}, o_err_cnt, m_err);
    check({nm, "_first_err"}, o_first_err_idx, m_first);
    check({nm, "_overflow"}, o_overflow, m_ovf);
    check({nm, "_timeout"}, o_timeout, 0);
    check({nm, "_busy"}, o_busy, 0);
    mon_en = 0; drv_en = 0;
  endtask

  typedef struct {
    int op_n, in_n, gd_n, rm, im, nout, bad;
    logic [15:0] e_err;
    logic [11:0] e_first;
    logic e_ovf;
  } vec_t;

  vec_t tab[6];

  initial begin
    bit ok;
    for (int i = 0; i < (1<<OP_AW); i++) op_rom[i] = OP_W'($urandom_range(0, 2));
    for (int i = 0; i < (1<<IN_AW); i++) in_rom[i] = DATA_W'($urandom);
    for (int i = 0; i < (1<<GD_AW); i++) gd_rom[i] = OUT_W'($urandom);
    op_rom[0] = 4'd1; op_rom[1] = 4'd0; op_rom[2] = 4'd2;
    gd_rom[0] = 14'd5; gd_rom[1] = 14'd7; gd_rom[2] = 14'd9;

    //       op  in    gd rm im nout bad  err    first  ovf
    tab[0] = '{3, 2048, 4, 1, 1, 4, -1, 16'd0, 12'd0, 1'b0};
    tab[1] = '{3, 16,   3, 2, 2, 3, -1, 16'd0, 12'd0, 1'b0};
    tab[2] = '{3, 0,    3, 1, 1, 3, -1, 16'd0, 12'd0, 1'b0};
    tab[3] = '{3, 4,    3, 1, 3, 4,  1, 16'd2, 12'd1, 1'b1};
    tab[4] = '{3, 2,    0, 1, 1, 0, -1, 16'd0, 12'd0, 1'b0};
    tab[5] = '{0, 5,    2, 1, 1, 2, -1, 16'd0, 12'd0, 1'b0};

    repeat (3) @(posedge i_clk);
    #2; i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_valids", {o_op_valid, o_in_valid}, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    check("rst_flags", {o_timeout, o_overflow}, 0);
    check("rst_state", o_dbg_state, S_IDLE);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < tab[t].nout; i++)
        out_words[i] = (i >= tab[t].gd_n) ? 14'd3 :
                       (i == tab[t].bad) ? gd_rom[i] + 14'd1 : gd_rom[i];
      run_case(tab[t].op_n, tab[t].in_n, tab[t].gd_n, tab[t].rm, tab[t].im, tab[t].nout,
               1'b1, tab[t].e_err, tab[t].e_first, tab[t].e_ovf, $sformatf("tab%0d", t));
    end

    // Watchdog: DUT never ready, limit 100 cycles after entering WAIT_RDY.
    rdy_mode = 0; in_mode = 1; n_out = 0;
    i_op_num = 11'd2; i_in_num = 12'd4; i_gold_num = '0; i_timeout = 16'd100;
    @(posedge i_clk); #3; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0; drv_en = 1; mon_en = 1;
    check("wd_enter_state", o_dbg_state, S_WAIT_RDY);
    repeat (99) @(posedge i_clk);
    #1;
    check("wd_done_early", o_done, 0);
    check("wd_flag_early", o_timeout, 0);
    @(posedge i_clk); #1;
    check("wd_done", o_done, 1);
    check("wd_flag", o_timeout, 1);
    check("wd_valids", {o_op_valid, o_in_valid, o_busy}, 0);
    check("wd_no_ops", got_ops.size(), 0);
    mon_en = 0; drv_en = 0; i_timeout = '0;

    // Async reset in the middle of a load burst, then a clean rerun.
    rdy_mode = 1; in_mode = 1; n_out = 0;
    i_op_num = 11'd3; i_in_num = 12'd2048; i_gold_num = '0;
    @(posedge i_clk); #3; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0; drv_en = 1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (o_in_valid) begin ok = 1; break; end
    end
    check("rstld_reached_load", 32'(ok), 1);
    repeat (10) @(negedge i_clk);
    #2; drv_en = 0; i_rst = 1'b1;
    #1;
    check("rstld_in_valid", o_in_valid, 0);
    check("rstld_op_valid", o_op_valid, 0);
    check("rstld_busy", o_busy, 0);
    #4; i_rst = 1'b0;
    for (int i = 0; i < 3; i++) out_words[i] = gd_rom[i];
    run_case(3, 8, 3, 1, 1, 3, 1'b1, 16'd0, 12'd0, 1'b0, "rstld_rerun");

    for (int r = 0; r < 16; r++) begin
      int op_n, in_n, gd_n, nout;
      op_n = $urandom_range(1, 6);
      in_n = $urandom_range(0, 20);
      gd_n = $urandom_range(0, 10);
      nout = gd_n + $urandom_range(0, 2);
      for (int i = 0; i < nout; i++)
        out_words[i] = (i < gd_n && $urandom_range(0, 3) != 0) ? gd_rom[i] : OUT_W'($urandom);
      run_case(op_n, in_n, gd_n, $urandom_range(1, 2), $urandom_range(1, 3), nout,
               1'b0, 16'd0, 12'd0, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
